// File: rtl/alu_arbiter.sv
// Two-requester, single-ALU arbiter: accept one op in IDLE, compute in EXEC, hold result in RESP.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (req0 first).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a request transfers on a rising edge where reqN_valid && reqN_ready;
  // a response transfers on a rising edge where rsp_valid && rsp_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             rsp_id_q, rsp_id_d;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] alu_res;

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  // On contention the requester not granted last wins.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_q);
    gnt1 = req1_valid && (!req0_valid || !last_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid && !req0_valid;
  end
`endif

  assign req0_ready = (state_q == IDLE) && !reset && gnt0;
  assign req1_ready = (state_q == IDLE) && !reset && gnt1;

  always_comb begin
    case (ctrl_q)
      4'b0000: alu_res = a_q & b_q;
      4'b0001: alu_res = a_q | b_q;
      4'b0010: alu_res = a_q + b_q;
      4'b0110: alu_res = a_q - b_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    id_d     = id_q;
    result_d = result_q;
    zero_d   = zero_q;
    rsp_id_d = rsp_id_q;
`ifdef ALU_ARB_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          a_d     = req0_a;
          b_d     = req0_b;
          ctrl_d  = req0_ctrl;
          id_d    = 1'b0;
          state_d = EXEC;
`ifdef ALU_ARB_RR_EN
          last_d  = 1'b0;
`endif
        end else if (req1_ready) begin
          a_d     = req1_a;
          b_d     = req1_b;
          ctrl_d  = req1_ctrl;
          id_d    = 1'b1;
          state_d = EXEC;
`ifdef ALU_ARB_RR_EN
          last_d  = 1'b1;
`endif
        end
      end
      EXEC: begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        rsp_id_d = id_q;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      rsp_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      id_q     <= id_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: per-requester op queues feed the drivers, expected
// responses are queued at stimulus time and compared when the response handshake occurs.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int RW = W + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_ctrl, req1_ctrl;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [W-1:0] rsp_result;
  logic [1:0]   dbg_state;

  typedef struct packed {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  int            checks = 0;
  int            failures = 0;
  logic [RW-1:0] exp_q[$];
  op_t           op0_q[$];
  op_t           op1_q[$];
  logic          hs0 = 1'b0;
  logic          hs1 = 1'b0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_zero", rsp_zero, 1);
    check("rst_result", rsp_result, 0);
    check("rst_id", rsp_id, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic id, input logic [3:0] ctrl, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    op_t op;
    op = '{ctrl: ctrl, a: a, b: b};
    if (id) op1_q.push_back(op);
    else    op0_q.push_back(op);
  endtask

  task automatic expect_rsp(input logic id, input logic zero, input logic [W-1:0] res);
    exp_q.push_back({id, zero, res});
  endtask

  function automatic logic [RW-1:0] model(input logic id, input logic [3:0] ctrl,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (ctrl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      default: r = '0;
    endcase
    return {id, (r == '0), r};
  endfunction

  initial begin : drv0
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
    forever begin
      @(negedge clk);
      if (hs0) void'(op0_q.pop_front());
      if (op0_q.size() > 0) begin
        req0_valid = 1'b1;
        req0_ctrl  = op0_q[0].ctrl;
        req0_a     = op0_q[0].a;
        req0_b     = op0_q[0].b;
      end else begin
        req0_valid = 1'b0;
      end
      #1 hs0 = req0_valid && req0_ready;
    end
  end

  initial begin : drv1
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    forever begin
      @(negedge clk);
      if (hs1) void'(op1_q.pop_front());
      if (op1_q.size() > 0) begin
        req1_valid = 1'b1;
        req1_ctrl  = op1_q[0].ctrl;
        req1_a     = op1_q[0].a;
        req1_b     = op1_q[0].b;
      end else begin
        req1_valid = 1'b0;
      end
      #1 hs1 = req1_valid && req1_ready;
    end
  end

  // ---------------- scoreboard ----------------
  initial begin : mon
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready && !reset) begin
        if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid, 0);
        else check("rsp", {rsp_id, rsp_zero, rsp_result}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_drain(input int budget, input bit rand_ready);
    int n = 0;
    while ((exp_q.size() > 0 || op0_q.size() > 0 || op1_q.size() > 0) && n < budget) begin
      @(posedge clk); #1;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("drain", exp_q.size(), 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_accept0(output int n);
    n = 0;
    while (!hs0 && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    logic [3:0] ctrl_tab[5];
    reset = 1'b1;
    rsp_ready = 1'b0;
    apply_reset();
    rsp_ready = 1'b1;

    // ADD with fixed two-edge latency, then signed wrap
    expect_rsp(1'b0, 1'b0, 32'd15);
    send(1'b0, 4'b0010, 32'd10, 32'd5);
    wait_accept0(n);
    check("t31_accept", hs0, 1);
    @(negedge clk);
    check("t31_exec", {rsp_valid, busy}, 2'b01);
    @(negedge clk);
    check("t31_lat2", rsp_valid, 1);
    wait_drain(50, 1'b0);
    expect_rsp(1'b0, 1'b0, 32'h8000_0000);
    send(1'b0, 4'b0010, 32'h7FFF_FFFF, 32'd1);
    wait_drain(50, 1'b0);

    // SUB to zero from requester 1
    expect_rsp(1'b1, 1'b1, 32'd0);
    send(1'b1, 4'b0110, 32'd20, 32'd20);
    wait_drain(50, 1'b0);

    // simultaneous AND / OR
    apply_reset();
    expect_rsp(1'b0, 1'b0, 32'h00FF_0000);
    expect_rsp(1'b1, 1'b0, 32'hFFFF_FFFF);
    send(1'b0, 4'b0000, 32'hFFFF_0000, 32'h00FF_00FF);
    send(1'b1, 4'b0001, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
    wait_drain(50, 1'b0);

    // both continuously valid
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      send(1'b0, 4'b0010, 32'(k), 32'd100);
      send(1'b1, 4'b0110, 32'(k + 1000), 32'd1);
    end
`ifdef ALU_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      expect_rsp(1'b0, 1'b0, 32'(k + 100));
      expect_rsp(1'b1, 1'b0, 32'(k + 999));
    end
`else
    for (int k = 0; k < 4; k++) expect_rsp(1'b0, 1'b0, 32'(k + 100));
    for (int k = 0; k < 4; k++) expect_rsp(1'b1, 1'b0, 32'(k + 999));
`endif
    wait_drain(200, 1'b0);

    // consumer back-pressure in RESP
    rsp_ready = 1'b0;
    expect_rsp(1'b0, 1'b0, 32'd7);
    send(1'b0, 4'b0010, 32'd3, 32'd4);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t35_reach_resp", rsp_valid, 1);
    expect_rsp(1'b1, 1'b0, 32'd3);
    send(1'b1, 4'b0001, 32'd1, 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t35_hold", {rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_zero, rsp_result},
            {6'b110000, 32'd7});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("t35_idle", {dbg_state, busy}, 3'b000);
    wait_drain(50, 1'b0);

    // illegal op code
    expect_rsp(1'b0, 1'b1, 32'd0);
    send(1'b0, 4'b1111, 32'd7, 32'd3);
    wait_drain(50, 1'b0);

    // reset while in EXEC drops the transaction
    send(1'b0, 4'b0010, 32'd1, 32'd1);
    wait_accept0(n);
    check("t36_accept", hs0, 1);
    @(posedge clk); #2;
    check("t36_in_exec", dbg_state, 2'd1);
    reset = 1'b1;
    #1;
    check("t36_rst_now", {rsp_valid, busy, dbg_state}, 4'b0000);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t36_no_rsp", {rsp_valid, busy}, 2'b00);
    end

    // random single-requester traffic with random back-pressure
    ctrl_tab[0] = 4'b0000; ctrl_tab[1] = 4'b0001; ctrl_tab[2] = 4'b0010;
    ctrl_tab[3] = 4'b0110; ctrl_tab[4] = 4'b0011;
    for (int t = 0; t < 24; t++) begin
      logic         rid;
      logic [3:0]   rc;
      logic [W-1:0] ra, rb;
      rid = 1'($urandom_range(0, 1));
      rc  = ctrl_tab[$urandom_range(0, 4)];
      ra  = $urandom;
      rb  = (t % 4 == 0) ? ra : $urandom;
      exp_q.push_back(model(rid, rc, ra, rb));
      send(rid, rc, ra, rb);
      wait_drain(100, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
